// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter timer: state encoding and default width.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage : counter_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot or periodic (auto-reload) mode.
// A registered one-cycle tc pulse marks each terminal count.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  state_e           w_state_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_tc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_state_next  = r_state;
    w_q_next      = r_q;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;

    if (load) begin
      w_q_next      = load_val;
      w_reload_next = load_val;
      w_state_next  = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (en) begin
            if (r_q > WIDTH'(1)) begin
              w_q_next = r_q - WIDTH'(1);
            end else if (r_q == WIDTH'(1)) begin
              w_tc_next = 1'b1;
              if (auto_reload) begin
                w_q_next = r_reload;
              end else begin
                w_q_next     = '0;
                w_state_next = ST_DONE;
              end
            end else begin
              // Unreachable zero count while running: stop without a pulse.
              w_state_next = ST_DONE;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          w_state_next = r_state;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  assign q  = r_q;
  assign tc = r_tc;

endmodule : down_counter_timer

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: load  input  1  load request; captures load_val into the counter and the reload register.
REQ-005 Port: load_val  input  WIDTH  start/reload value, unsigned.
REQ-006 Port: en  input  1  count enable; decrement permitted only when high.
REQ-007 Port: auto_reload  input  1  selects periodic mode, sampled at the terminal-count cycle.
REQ-008 Port: q  output  WIDTH  current count, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-010 Port: busy  output  1  high while state is RUN.
REQ-011 Port: done  output  1  high while state is DONE.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 load=1 in any state SHALL set q<=load_val and reload_reg<=load_val next edge; next state RUN if load_val!=0, else IDLE.
REQ-014 load SHALL take priority over en and over the terminal-count action in the same cycle; no tc is generated on a load cycle.
REQ-015 In RUN with en=1 and q>1, q SHALL decrement by 1 per cycle, modulo-free (no wrap).
REQ-016 In RUN with en=1 and q==1, the block SHALL assert tc on the next cycle, and:
  - auto_reload=0: q<=0, next state DONE;
  - auto_reload=1: q<=reload_reg, remain RUN (period = reload_reg cycles, q never shows 0).
REQ-017 In RUN with en=0, q and state SHALL hold; tc=0.
REQ-018 In IDLE and DONE, en SHALL be ignored; q SHALL hold (0 after terminal count); no underflow below 0 under any input.
REQ-019 tc SHALL be high for exactly one cycle per terminal count and low otherwise.
REQ-020 busy = (state==RUN); done = (state==DONE); both registered-state decodes, no combinational path from inputs.
REQ-021 Latency: load to q update one cycle; q==1 with en to tc high and q update one cycle.

Reset
REQ-022 rst=1 at a rising edge SHALL force q=0, reload_reg=0, tc=0, state=IDLE (busy=0, done=0) regardless of other inputs.
REQ-023 rst SHALL have priority over load and en; reset mid-count SHALL abandon the count with no tc.
REQ-024 After rst deasserts, the block SHALL remain in IDLE until a load with a nonzero value.

Structure
REQ-025 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package counter_pkg.
REQ-026 The design SHALL be one module with no sub-modules: one state register, one count register, one reload register, one tc register.
REQ-027 All sequential logic SHALL be synchronous to clk; no derived or rippled clocks.

Verification (WIDTH=4)
REQ-028 rst, load 5 (auto_reload=0), en=1 steady -> q 5,4,3,2,1,0; tc high only in cycle q=0 appears; done=1, busy=0 thereafter; q stays 0.
REQ-029 load 3, auto_reload=1, en=1 steady -> q 3,2,1,3,2,1,...; tc pulses once every 3 cycles; busy stays 1.
REQ-030 load 4, en=1 for 2 cycles then 0 for 3 cycles -> q 4,3,2,2,2,2; no tc; busy=1.
REQ-031 while counting at q=2, assert load with load_val=9 and en=1 -> q=9 next cycle, no tc; counts down from 9.
REQ-032 load 0 -> q=0, state IDLE, no tc, busy=0 and done=0; subsequent load 15 -> counts 15..0 with one tc.
REQ-033 rst asserted at q=6 while counting with load=1 in the same cycle -> q=0, IDLE, tc=0 next cycle.
